// File: rtl/gate_response_checker.sv
// Checks a NAND-built basic-gate block against ideal Boolean results. It counts
// mismatching samples, records which {a,b} combinations were seen, and reports pass/fail.
module gate_response_checker #(
    parameter int NUM_VECTORS = 4,
    parameter int ERR_W       = 8,
    parameter int TIMEOUT     = 64,
    localparam int CNT_W      = $clog2(NUM_VECTORS + 1),
    localparam int TMR_W      = $clog2(TIMEOUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic             a,
    input  logic             b,
    input  logic             and_in,
    input  logic             or_in,
    input  logic             not_in,
    input  logic             xor_in,
    input  logic             xnor_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timed_out,
    output logic [ERR_W-1:0] err_count,
    output logic [4:0]       mismatch_vec,
    output logic [3:0]       coverage,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_VECTORS - 1);
    localparam logic [TMR_W-1:0] LAST_TMR  = TMR_W'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam logic             COV_REACH = (NUM_VECTORS >= 4);

    state_t           state_q, state_d;
    logic             pass_q, pass_d;
    logic             timed_out_q, timed_out_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [4:0]       mm_q, mm_d;
    logic [3:0]       cov_q, cov_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic [4:0] exp_vec;
    logic [4:0] obs_vec;
    logic [4:0] mm_now;
    logic [3:0] cov_hit;

    assign exp_vec = {a & b, a | b, ~a, a ^ b, ~(a ^ b)};
    assign obs_vec = {and_in, or_in, not_in, xor_in, xnor_in};
    assign mm_now  = obs_vec ^ exp_vec;

    // One-hot decode of the current {a,b} combination.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cov
            assign cov_hit[gi] = ({a, b} == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        timed_out_d = timed_out_q;
        err_d       = err_q;
        mm_d        = mm_q;
        cov_d       = cov_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    pass_d      = 1'b0;
                    timed_out_d = 1'b0;
                    err_d       = '0;
                    mm_d        = '0;
                    cov_d       = '0;
                    cnt_d       = '0;
                    tmr_d       = '0;
                end
            end
            ST_RUN: begin
                if (sample_valid) begin
                    mm_d  = mm_now;
                    if ((|mm_now) && (err_q != ERR_MAX)) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    cov_d = cov_q | cov_hit;
                    cnt_d = cnt_q + CNT_W'(1);
                    tmr_d = '0;
                    // Verdict uses the totals that include this final sample.
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                        pass_d  = (err_d == '0) && (cov_d == 4'hF) && COV_REACH;
                    end
                end else if (tmr_q == LAST_TMR) begin
                    state_d     = ST_DONE;
                    timed_out_d = 1'b1;
                    pass_d      = 1'b0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            err_q       <= '0;
            mm_q        <= '0;
            cov_q       <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            timed_out_q <= timed_out_d;
            err_q       <= err_d;
            mm_q        <= mm_d;
            cov_q       <= cov_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
        end
    end

    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign pass         = pass_q;
    assign timed_out    = timed_out_q;
    assign err_count    = err_q;
    assign mismatch_vec = mm_q;
    assign coverage     = cov_q;
    assign sample_cnt   = cnt_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Scenario bench for gate_response_checker. Expected per-sample results are queued
// when a sample is driven and compared when the registered result appears.
module tb_gate_response_checker;

    logic clk = 1'b0;
    logic rst, start, sample_valid, a, b, and_in, or_in, not_in, xor_in, xnor_in;

    logic       busy, done, pass, timed_out;
    logic [7:0] err_count;
    logic [4:0] mismatch_vec;
    logic [3:0] coverage;
    logic [2:0] sample_cnt;

    logic       busy2, done2, pass2, timed_out2;
    logic [1:0] err_count2;
    logic [4:0] mismatch_vec2;
    logic [3:0] coverage2;
    logic [2:0] sample_cnt2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [4:0] mm;
        logic [7:0] err;
        logic [3:0] cov;
        logic [2:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_err;
    logic [3:0] m_cov;
    logic [2:0] m_cnt;

    always #5 clk = ~clk;

    gate_response_checker dut (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .a(a), .b(b), .and_in(and_in), .or_in(or_in), .not_in(not_in),
        .xor_in(xor_in), .xnor_in(xnor_in),
        .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
        .err_count(err_count), .mismatch_vec(mismatch_vec),
        .coverage(coverage), .sample_cnt(sample_cnt)
    );

    gate_response_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .a(a), .b(b), .and_in(and_in), .or_in(or_in), .not_in(not_in),
        .xor_in(xor_in), .xnor_in(xnor_in),
        .busy(busy2), .done(done2), .pass(pass2), .timed_out(timed_out2),
        .err_count(err_count2), .mismatch_vec(mismatch_vec2),
        .coverage(coverage2), .sample_cnt(sample_cnt2)
    );

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_err = '0; m_cov = '0; m_cnt = '0;
        total_cnt++;
        if (busy !== 1'b1 || err_count !== 8'd0 || coverage !== 4'd0 || sample_cnt !== 3'd0)
            $display("FAIL start_clear: busy=%b err=%0d cov=%b cnt=%0d, want busy=1 err=0 cov=0000 cnt=0",
                     busy, err_count, coverage, sample_cnt);
        else pass_cnt++;
    endtask

    task automatic send(input logic va, input logic vb, input logic xor_stuck, input logic inv_all);
        logic [4:0] ideal, outs;
        exp_t e, got;
        ideal = {va & vb, va | vb, ~va, va ^ vb, ~(va ^ vb)};
        outs  = ideal;
        if (xor_stuck) outs[1] = 1'b0;
        if (inv_all)   outs = ~ideal;
        a = va; b = vb;
        {and_in, or_in, not_in, xor_in, xnor_in} = outs;
        sample_valid = 1'b1;
        e.mm = outs ^ ideal;
        if (e.mm != 5'd0 && m_err != 8'hFF) m_err = m_err + 8'd1;
        m_cov[{va, vb}] = 1'b1;
        m_cnt = m_cnt + 3'd1;
        e.err = m_err; e.cov = m_cov; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        got = sb.pop_front();
        total_cnt++;
        if (mismatch_vec !== got.mm || err_count !== got.err || coverage !== got.cov || sample_cnt !== got.cnt)
            $display("FAIL sample ab=%0d%0d: mm=%b err=%0d cov=%b cnt=%0d, want mm=%b err=%0d cov=%b cnt=%0d",
                     va, vb, mismatch_vec, err_count, coverage, sample_cnt, got.mm, got.err, got.cov, got.cnt);
        else pass_cnt++;
    endtask

    task automatic sweep(input logic [7:0] ab4, input logic xs, input logic inv);
        for (int i = 3; i >= 0; i--) send(ab4[2*i+1], ab4[2*i], xs, inv);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; sample_valid = 0; a = 0; b = 0;
        {and_in, or_in, not_in, xor_in, xnor_in} = 5'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        total_cnt++;
        if ({busy, done, pass, timed_out} !== 4'd0) $display("FAIL reset_flags: %b want 0000", {busy, done, pass, timed_out});
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 8'd0 || mismatch_vec !== 5'd0) $display("FAIL reset_err: err=%0d mm=%b want 0", err_count, mismatch_vec);
        else pass_cnt++;
        total_cnt++;
        if (coverage !== 4'd0 || sample_cnt !== 3'd0) $display("FAIL reset_cov: cov=%b cnt=%0d want 0", coverage, sample_cnt);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_hold: busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
    endtask

    task automatic test_clean_sweep();
        pulse_start();
        sweep(8'b00_01_10_11, 1'b0, 1'b0);
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || timed_out !== 1'b0)
            $display("FAIL clean_end: done=%b busy=%b pass=%b to=%b want 1 0 1 0", done, busy, pass, timed_out);
        else pass_cnt++;
    endtask

    task automatic test_stuck_xor();
        pulse_start();
        sweep(8'b00_01_10_11, 1'b1, 1'b0);
        total_cnt++;
        if (done !== 1'b1 || pass !== 1'b0 || err_count !== 8'd2)
            $display("FAIL stuck_xor_end: done=%b pass=%b err=%0d want 1 0 2", done, pass, err_count);
        else pass_cnt++;
    endtask

    task automatic test_restart();
        pulse_start();
        sweep(8'b11_10_01_00, 1'b0, 1'b0);
        total_cnt++;
        if (done !== 1'b1 || pass !== 1'b1) $display("FAIL restart_end: done=%b pass=%b want 1 1", done, pass);
        else pass_cnt++;
    endtask

    task automatic test_partial_cov();
        pulse_start();
        sweep(8'b00_00_11_11, 1'b0, 1'b0);
        total_cnt++;
        if (done !== 1'b1 || pass !== 1'b0 || coverage !== 4'b1001 || err_count !== 8'd0)
            $display("FAIL partial_end: done=%b pass=%b cov=%b err=%0d want 1 0 1001 0", done, pass, coverage, err_count);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int idle = 0;
        pulse_start();
        send(1'b0, 1'b1, 1'b0, 1'b0);
        while (done !== 1'b1 && idle < 200) begin
            @(posedge clk); #1;
            idle++;
        end
        total_cnt++;
        if (idle !== 64) $display("FAIL timeout_cycles: got %0d want 64", idle);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b1 || timed_out !== 1'b1 || pass !== 1'b0 || sample_cnt !== 3'd1 || busy !== 1'b0)
            $display("FAIL timeout_end: done=%b to=%b pass=%b cnt=%0d busy=%b want 1 1 0 1 0",
                     done, timed_out, pass, sample_cnt, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        pulse_start();
        sweep(8'b00_01_10_11, 1'b0, 1'b0);
        pulse_start();
        send(1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        send(1'b1, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) $display("FAIL b2b_end: done=%b busy=%b pass=%b want 1 0 1", done, busy, pass);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || sample_cnt !== 3'd4) $display("FAIL b2b_hold: done=%b busy=%b cnt=%0d want 1 0 4", done, busy, sample_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        pulse_start();
        send(1'b0, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if ({busy, done, pass, timed_out} !== 4'd0 || err_count !== 8'd0 || mismatch_vec !== 5'd0 || coverage !== 4'd0 || sample_cnt !== 3'd0)
            $display("FAIL midrun_reset: flags=%b err=%0d mm=%b cov=%b cnt=%0d want all 0",
                     {busy, done, pass, timed_out}, err_count, mismatch_vec, coverage, sample_cnt);
        else pass_cnt++;
        pulse_start();
        sweep(8'b00_01_10_11, 1'b0, 1'b0);
        total_cnt++;
        if (done !== 1'b1 || pass !== 1'b1) $display("FAIL midrun_recover: done=%b pass=%b want 1 1", done, pass);
        else pass_cnt++;
    endtask

    task automatic test_err_saturate();
        pulse_start();
        sweep(8'b00_01_10_11, 1'b0, 1'b1);
        total_cnt++;
        if (err_count2 !== 2'd3 || done2 !== 1'b1 || pass2 !== 1'b0)
            $display("FAIL err_saturate: err=%0d done=%b pass=%b want 3 1 0", err_count2, done2, pass2);
        else pass_cnt++;
        total_cnt++;
        if (mismatch_vec2 !== 5'b11111 || coverage2 !== 4'hF || sample_cnt2 !== 3'd4 || timed_out2 !== 1'b0 || busy2 !== 1'b0)
            $display("FAIL err_sat_misc: mm=%b cov=%b cnt=%0d to=%b busy=%b want 11111 1111 4 0 0",
                     mismatch_vec2, coverage2, sample_cnt2, timed_out2, busy2);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_stuck_xor();
        test_restart();
        test_partial_cov();
        test_timeout();
        test_back_to_back();
        test_reset_midrun();
        test_err_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
